// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline hazard/sequencing controller: instruction
// field positions, opcode and aluop encodings, and the multdiv FSM states.
package pipeline_ctrl_pkg;

  localparam int unsigned MD_TIMEOUT_DEFAULT = 64;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  // Opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type aluops that need the multi-cycle unit
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a lw in DX whose destination is read by the FD instruction.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0] ir_fd_i,
  input  logic [31:0] ir_dx_i,
  output logic        stall_lu_o
);

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_rd;
  logic       use_rd, use_rs, use_rt;
  logic       unused_bits;

  assign fd_op = ir_fd_i[OPC_MSB:OPC_LSB];
  assign fd_rd = ir_fd_i[RD_MSB:RD_LSB];
  assign fd_rs = ir_fd_i[RS_MSB:RS_LSB];
  assign fd_rt = ir_fd_i[RT_MSB:RT_LSB];
  assign dx_rd = ir_dx_i[RD_MSB:RD_LSB];

  // Immediates, shamt and aluop never name a register.
  assign unused_bits = ^{ir_fd_i[11:0], ir_dx_i[21:0]};

  // Decide which FD fields are register sources, then compare against the lw target.
  always_comb begin
    use_rd = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    unique case (fd_op)
      OP_RTYPE:                    begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI, OP_LW:              use_rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT, OP_JR: begin use_rd = 1'b1; use_rs = 1'b1; end
      default: ;
    endcase
    stall_lu_o = (ir_dx_i[OPC_MSB:OPC_LSB] == OP_LW) && (dx_rd != 5'd0) &&
                 ((use_rd && (fd_rd == dx_rd)) ||
                  (use_rs && (fd_rs == dx_rd)) ||
                  (use_rt && (fd_rt == dx_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch enable / bubble controller with multdiv start-ready sequencing.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] ir_fd,
  input  logic [31:0] ir_dx,
  input  logic [31:0] ir_xm,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        we_pc,
  output logic        we_fd,
  output logic        we_dx,
  output logic        we_xm,
  output logic        we_mw,
  output logic        nop_fd,
  output logic        nop_dx,
  output logic        nop_xm,
  output logic        md_start,
  output logic        md_error,
  output logic [15:0] stall_count
);

  localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  md_state_e        state_q, state_d;
  logic             md_start_q, md_start_d;
  logic             md_error_q, md_error_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             stall_lu;
  logic             is_md;
  logic             unused_xm;

  // XM instruction is not needed by the current hazard rules; kept for datapath wiring.
  assign unused_xm = ^ir_xm;

  hazard_detect u_hazard (
    .ir_fd_i    (ir_fd),
    .ir_dx_i    (ir_dx),
    .stall_lu_o (stall_lu)
  );

  assign is_md = (ir_dx[OPC_MSB:OPC_LSB] == OP_RTYPE) &&
                 ((ir_dx[ALU_MSB:ALU_LSB] == ALU_MUL) || (ir_dx[ALU_MSB:ALU_LSB] == ALU_DIV));

  // Next state and latch controls; reset forces the default (free-running) controls.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    md_error_d = md_error_q;
    md_start_d = 1'b0;
    we_pc  = 1'b1;
    we_fd  = 1'b1;
    we_dx  = 1'b1;
    we_xm  = 1'b1;
    we_mw  = 1'b1;
    nop_fd = 1'b0;
    nop_dx = 1'b0;
    nop_xm = 1'b0;
    if (!ctrl_reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_md && !branch_taken) begin
            // Freeze starts the cycle the mul/div first appears in DX.
            state_d    = ST_MD_BUSY;
            md_start_d = 1'b1;
            tmo_d      = CNT_W'(MD_TIMEOUT - 1);
            we_pc  = 1'b0;
            we_fd  = 1'b0;
            we_dx  = 1'b0;
            nop_xm = 1'b1;
          end else if (branch_taken) begin
            nop_fd = 1'b1;
            nop_dx = 1'b1;
          end else if (stall_lu) begin
            we_pc  = 1'b0;
            we_fd  = 1'b0;
            nop_dx = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          // Load-use is irrelevant here: FD is frozen regardless.
          we_pc  = 1'b0;
          we_fd  = 1'b0;
          we_dx  = 1'b0;
          nop_xm = 1'b1;
          if (md_ready && !md_start_q) begin
            state_d = ST_MD_DONE;
          end else if (tmo_q == '0) begin
            md_error_d = 1'b1;
            state_d    = ST_MD_DONE;
          end else begin
            tmo_d = tmo_q - CNT_W'(1);
          end
        end
        ST_MD_DONE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
    stall_cnt_d = stall_cnt_q;
    if (!we_pc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State, start pulse, sticky error, timeout and stall counters.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q     <= ST_IDLE;
      md_start_q  <= 1'b0;
      md_error_q  <= 1'b0;
      tmo_q       <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_start_q  <= md_start_d;
      md_error_q  <= md_error_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_start    = md_start_q;
  assign md_error    = md_error_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed cases plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic [31:0] ir_fd, ir_dx, ir_xm;
  logic        branch_taken, md_ready;
  logic        we_pc, we_fd, we_dx, we_xm, we_mw;
  logic        nop_fd, nop_dx, nop_xm;
  logic        md_start, md_error;
  logic [15:0] stall_count;

  pipeline_ctrl dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .ir_fd        (ir_fd),
    .ir_dx        (ir_dx),
    .ir_xm        (ir_xm),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .we_pc        (we_pc),
    .we_fd        (we_fd),
    .we_dx        (we_dx),
    .we_xm        (we_xm),
    .we_mw        (we_mw),
    .nop_fd       (nop_fd),
    .nop_dx       (nop_dx),
    .nop_xm       (nop_xm),
    .md_start     (md_start),
    .md_error     (md_error),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting on multdiv, 2 result handoff.
  int ph, bcnt, m_stall;
  bit m_start, m_err;
  int last_ph;
  bit last_we_pc, last_start;

  int ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22};

  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int sh, input int alu);
    logic [31:0] w;
    w = {op[4:0], rd[4:0], rs[4:0], rt[4:0], sh[4:0], alu[4:0], 2'b00};
    return w;
  endfunction

  function automatic bit is_md_m(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
  endfunction

  function automatic bit lu_model(input logic [31:0] fd, input logic [31:0] dx);
    int srcs[$];
    if ((dx[31:27] != 5'd8) || (dx[26:22] == 5'd0)) return 1'b0;
    case (int'(fd[31:27]))
      0:          begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[16:12])); end
      5, 8:       srcs.push_back(int'(fd[21:17]));
      2, 4, 6, 7: begin srcs.push_back(int'(fd[26:22])); srcs.push_back(int'(fd[21:17])); end
      default: ;
    endcase
    foreach (srcs[i]) if (srcs[i] == int'(dx[26:22])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rnd_instr();
    return mk(ops[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 7));
  endfunction

  task automatic model_zero();
    ph = 0; bcnt = 0; m_stall = 0; m_start = 1'b0; m_err = 1'b0;
  endtask

  // One clock: check at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    logic [7:0] e;
    int  n_ph, n_bcnt, n_stall;
    bit  n_start, n_err;
    @(negedge clock);
    e = 8'hF8;  // {we_pc,we_fd,we_dx,we_xm,we_mw,nop_fd,nop_dx,nop_xm}
    n_ph = ph; n_bcnt = bcnt; n_start = 1'b0; n_err = m_err;
    case (ph)
      0: begin
        if (is_md_m(ir_dx) && !branch_taken) begin
          e[7] = 1'b0; e[6] = 1'b0; e[5] = 1'b0; e[0] = 1'b1;
          n_ph = 1; n_bcnt = 1; n_start = 1'b1;
        end else if (branch_taken) begin
          e[2] = 1'b1; e[1] = 1'b1;
        end else if (lu_model(ir_fd, ir_dx)) begin
          e[7] = 1'b0; e[6] = 1'b0; e[1] = 1'b1;
        end
      end
      1: begin
        e[7] = 1'b0; e[6] = 1'b0; e[5] = 1'b0; e[0] = 1'b1;
        if (md_ready && (bcnt != 1)) n_ph = 2;
        else if (bcnt == 64) begin n_err = 1'b1; n_ph = 2; end
        else n_bcnt = bcnt + 1;
      end
      default: n_ph = 0;
    endcase
    n_stall = m_stall;
    if (!e[7] && (m_stall < 65535)) n_stall = m_stall + 1;
    check("ctl", 32'({we_pc, we_fd, we_dx, we_xm, we_mw, nop_fd, nop_dx, nop_xm}), 32'(e));
    check("md_start", 32'(md_start), 32'(m_start));
    check("md_error", 32'(md_error), 32'(m_err));
    check("stall_count", 32'(stall_count), 32'(m_stall));
    last_ph = ph; last_we_pc = we_pc; last_start = md_start;
    @(posedge clock);
    #1;
    ph = n_ph; bcnt = n_bcnt; m_start = n_start; m_err = n_err; m_stall = n_stall;
  endtask

  task automatic benign();
    ir_fd = 32'd0; ir_dx = 32'd0; ir_xm = 32'd0; branch_taken = 1'b0; md_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset = 1'b1;
    benign();
    #1;
    model_zero();
    @(negedge clock);
    ctrl_reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Start a mul, assert reset asynchronously inside BUSY cycle k.
  task automatic reset_mid(input int k);
    ir_dx = mk(0, 5, 1, 2, 0, 6);
    md_ready = 1'b0;
    cycle();
    for (int i = 1; i < k; i++) cycle();
    #2;
    ctrl_reset = 1'b1;
    benign();
    #1;
    check("rst_mid_ctl", 32'({we_pc, we_fd, we_dx, we_xm, we_mw, nop_fd, nop_dx, nop_xm}), 32'h0F8);
    check("rst_mid_start", 32'(md_start), 32'd0);
    check("rst_mid_error", 32'(md_error), 32'd0);
    check("rst_mid_stall", 32'(stall_count), 32'd0);
    model_zero();
    @(negedge clock);
    ctrl_reset = 1'b0;
    @(posedge clock);
    #1;
    cycle();
  endtask

  initial begin
    int cnt_stall, cnt_start;
    bit reached;
    ctrl_reset = 1'b1;
    benign();
    model_zero();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ctl", 32'({we_pc, we_fd, we_dx, we_xm, we_mw, nop_fd, nop_dx, nop_xm}), 32'h0F8);
    check("rst_start", 32'(md_start), 32'd0);
    check("rst_error", 32'(md_error), 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    ctrl_reset = 1'b0;
    @(posedge clock);
    #1;

    // Load-use: lw $3,0($1) in DX, add $4,$3,$2 in FD
    ir_dx = mk(8, 3, 1, 0, 0, 0);
    ir_fd = mk(0, 4, 3, 2, 0, 0);
    cycle();
    check("lu_count", 32'(stall_count), 32'd1);
    ir_dx = 32'd0;
    cycle();

    // lw to $0 never stalls
    ir_dx = mk(8, 0, 1, 0, 0, 0);
    ir_fd = mk(0, 4, 0, 2, 0, 0);
    cycle();
    check("lu_r0_count", 32'(stall_count), 32'd1);

    // Branch overrides load-use
    ir_dx = mk(8, 3, 1, 0, 0, 0);
    ir_fd = mk(0, 4, 3, 2, 0, 0);
    branch_taken = 1'b1;
    cycle();
    check("br_lu_count", 32'(stall_count), 32'd1);
    benign();
    cycle();

    // mul with ready in its 5th BUSY cycle
    do_reset();
    ir_dx = mk(0, 5, 1, 2, 0, 6);
    cnt_stall = 0; cnt_start = 0; reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      md_ready = (ph == 1) && (bcnt == 5);
      cycle();
      if (!last_we_pc) cnt_stall++;
      if (last_start) cnt_start++;
      if (last_ph == 2) reached = 1'b1;
    end
    check("mul_done_reached", 32'(reached), 32'd1);
    check("mul_stall_cycles", 32'(cnt_stall), 32'd6);
    check("mul_start_pulses", 32'(cnt_start), 32'd1);
    check("mul_stall_count", 32'(stall_count), 32'd6);
    benign();
    cycle();

    // div timeout: ready never arrives
    ir_dx = mk(0, 6, 1, 2, 0, 7);
    cnt_stall = 0; reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      cycle();
      if (!last_we_pc) cnt_stall++;
      if (last_ph == 2) reached = 1'b1;
    end
    check("tmo_done_reached", 32'(reached), 32'd1);
    check("tmo_stall_cycles", 32'(cnt_stall), 32'd65);
    check("tmo_error", 32'(md_error), 32'd1);
    benign();
    repeat (4) cycle();
    check("tmo_error_sticky", 32'(md_error), 32'd1);

    // Asynchronous reset inside BUSY
    reset_mid(3);
    reset_mid(1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (ph == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: ir_dx = mk(8, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
          3:       ir_dx = mk(0, $urandom_range(0, 3), 1, 2, 0, $urandom_range(6, 7));
          default: ir_dx = rnd_instr();
        endcase
        ir_fd = rnd_instr();
        branch_taken = ($urandom_range(0, 5) == 0);
      end else begin
        branch_taken = 1'b0;
      end
      ir_xm = $urandom;
      md_ready = ($urandom_range(0, 4) == 0);
      cycle();
    end

    // stall_count saturation
    do_reset();
    ir_dx = mk(8, 3, 1, 0, 0, 0);
    ir_fd = mk(0, 4, 3, 2, 0, 0);
    repeat (65540) @(posedge clock);
    @(negedge clock);
    check("stall_saturate", 32'(stall_count), 32'h0000FFFF);
    check("sat_we_pc", 32'(we_pc), 32'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
